// File: rtl/mdu_unit_pkg.sv
// mdu_unit_pkg: shared definitions for the RV M-extension multiply/divide unit.
//   XLEN        operand/result width (32, or 64 when __RV64__ is defined)
//   OP_*        bit positions inside the one-hot op vector from the decoder
//   mdu_state_t FSM state encoding (IDLE/MUL/DIV/DONE)
//   lowest_bit  isolates the lowest set bit of a (possibly multi-hot) op vector
//   mag         two's-complement magnitude when the operand is treated as signed
package mdu_unit_pkg;

`ifdef __RV64__
  localparam int XLEN = 64;
`else
  localparam int XLEN = 32;
`endif

  localparam int OP_W      = 8;
  localparam int OP_MUL    = 0;
  localparam int OP_MULH   = 1;
  localparam int OP_MULHSU = 2;
  localparam int OP_MULHU  = 3;
  localparam int OP_DIV    = 4;
  localparam int OP_DIVU   = 5;
  localparam int OP_REM    = 6;
  localparam int OP_REMU   = 7;

  localparam logic [XLEN-1:0] XMIN = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2,
    S_DONE = 2'd3
  } mdu_state_t;

  function automatic logic [OP_W-1:0] lowest_bit(input logic [OP_W-1:0] v);
    return v & (-v);
  endfunction

  function automatic logic [XLEN-1:0] mag(input logic [XLEN-1:0] x, input logic is_signed);
    return (is_signed && x[XLEN-1]) ? -x : x;
  endfunction

endpackage

// File: rtl/mdu_div_core.sv
// mdu_div_core: iterative unsigned restoring radix-2 divider, one quotient bit per cycle.
//   clk        core clock, rising edge
//   rst        asynchronous reset, active-high
//   start      load dividend/divisor and begin; takes priority over a running division
//   dividend   unsigned dividend (sampled on start)
//   divisor    unsigned divisor (sampled on start, must be non-zero for a meaningful result)
//   busy       high for exactly XLEN cycles after start
//   quotient   final quotient once busy falls
//   remainder  final remainder once busy falls
module mdu_div_core
  import mdu_unit_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  output logic            busy,
  output logic [XLEN-1:0] quotient,
  output logic [XLEN-1:0] remainder
);

  localparam int CW = $clog2(XLEN);

  logic [CW-1:0]   count_reg;
  logic            busy_reg;
  logic [XLEN-1:0] part_reg;   // partial remainder, always < divisor
  logic [XLEN-1:0] quo_reg;    // dividend bits shift out the top, quotient bits in the bottom
  logic [XLEN-1:0] dsr_reg;

  logic [XLEN:0] shifted;
  logic [XLEN:0] diff;

  // Because part_reg < divisor, shifted < 2*divisor, so a non-negative diff
  // always fits XLEN bits and diff[XLEN] is a clean borrow flag.
  assign shifted = {part_reg, quo_reg[XLEN-1]};
  assign diff    = shifted - {1'b0, dsr_reg};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_reg <= '0;
      busy_reg  <= 1'b0;
      part_reg  <= '0;
      quo_reg   <= '0;
      dsr_reg   <= '0;
    end else if (start) begin
      count_reg <= CW'(XLEN - 1);
      busy_reg  <= 1'b1;
      part_reg  <= '0;
      quo_reg   <= dividend;
      dsr_reg   <= divisor;
    end else if (busy_reg) begin
      if (diff[XLEN]) begin
        part_reg <= shifted[XLEN-1:0];
        quo_reg  <= {quo_reg[XLEN-2:0], 1'b0};
      end else begin
        part_reg <= diff[XLEN-1:0];
        quo_reg  <= {quo_reg[XLEN-2:0], 1'b1};
      end
      if (count_reg == '0) begin
        busy_reg <= 1'b0;
      end else begin
        count_reg <= count_reg - CW'(1);
      end
    end
  end

  assign busy      = busy_reg;
  assign quotient  = quo_reg;
  assign remainder = part_reg;

endmodule

// File: rtl/mdu_unit.sv
// mdu_unit: multicycle RV M-extension execute unit (mul/mulh/mulhsu/mulhu/div/divu/rem/remu).
//   clk        core clock, rising edge
//   rst        asynchronous reset, active-high
//   in_valid   operation request
//   in_ready   high only in IDLE
//   op         one-hot {remu,rem,divu,div,mulhu,mulhsu,mulh,mul}; lowest set bit wins
//   rs1, rs2   operands, latched on accept
//   flush      kills the in-flight op at the next edge; result is left untouched
//   out_valid  high exactly in DONE, held until out_ready
//   out_ready  consumer takes the result
//   result     rd value, stable while out_valid
// Build option MDU_ITER_MUL_EN: shift-add multiplier (XLEN iterations) instead of
// a single-cycle combinational multiply.
module mdu_unit
  import mdu_unit_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [OP_W-1:0] op,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result
);

  mdu_state_t state_reg, state_next;
  logic [XLEN-1:0] result_reg, result_next;

  // Decode of the incoming request
  logic [OP_W-1:0] op_sel;
  logic            accept;
  logic            is_mul, is_div;
  logic            sgn_a, sgn_b;
  logic [XLEN-1:0] a_mag, b_mag;
  logic            neg_q, neg_r;
  logic            special;
  logic [XLEN-1:0] spec_val;

  // Attributes of the accepted op
  logic            want_low_reg;   // mul: low half of the product
  logic            want_rem_reg;   // rem/remu: remainder instead of quotient
  logic            special_reg;
  logic [XLEN-1:0] spec_val_reg;
  logic            neg_q_reg;      // negate quotient / high product
  logic            neg_r_reg;      // negate remainder

  assign op_sel = lowest_bit(op);
  assign accept = in_valid && (state_reg == S_IDLE) && !flush;
  assign is_mul = |op_sel[OP_MULHU:OP_MUL];
  assign is_div = |op_sel[OP_REMU:OP_DIV];
  assign sgn_a  = op_sel[OP_MULH] | op_sel[OP_MULHSU] | op_sel[OP_DIV] | op_sel[OP_REM];
  assign sgn_b  = op_sel[OP_MULH] | op_sel[OP_DIV] | op_sel[OP_REM];
  assign a_mag  = mag(rs1, sgn_a);
  assign b_mag  = mag(rs2, sgn_b);
  assign neg_q  = (sgn_a & rs1[XLEN-1]) ^ (sgn_b & rs2[XLEN-1]);
  assign neg_r  = sgn_a & rs1[XLEN-1];

  // Cases that are resolved without iterating. They still pass through the
  // DIV state for one cycle so every non-iterating op has the same latency.
  always_comb begin
    special  = 1'b0;
    spec_val = '0;
    if (op_sel == '0) begin
      special = 1'b1;
    end else if (is_div && rs2 == '0) begin
      special  = 1'b1;
      spec_val = (op_sel[OP_DIV] | op_sel[OP_DIVU]) ? '1 : rs1;
    end else if ((op_sel[OP_DIV] | op_sel[OP_REM]) && rs1 == XMIN && rs2 == '1) begin
      special  = 1'b1;
      spec_val = op_sel[OP_DIV] ? XMIN : '0;
    end
  end

  // Divider path
  logic            div_busy;
  logic [XLEN-1:0] div_q, div_r;
  logic [XLEN-1:0] div_res;

  mdu_div_core u_div (
    .clk       (clk),
    .rst       (rst),
    .start     (accept && is_div && !special),
    .dividend  (a_mag),
    .divisor   (b_mag),
    .busy      (div_busy),
    .quotient  (div_q),
    .remainder (div_r)
  );

  assign div_res = want_rem_reg ? (neg_r_reg ? -div_r : div_r)
                                : (neg_q_reg ? -div_q : div_q);

  // Multiplier path
  logic            mul_done;
  logic [XLEN-1:0] mul_res;

`ifdef MDU_ITER_MUL_EN
  localparam int CW = $clog2(XLEN + 1);

  logic [CW-1:0]     cnt_reg;     // iterations remaining, XLEN down to 0
  logic [XLEN-1:0]   mcand_reg;
  logic [2*XLEN-1:0] acc_reg;     // {partial product, multiplier bits not yet consumed}
  logic [XLEN:0]     acc_sum;
  logic [2*XLEN-1:0] acc_step;
  logic [2*XLEN-1:0] acc_fix;

  assign acc_sum  = {1'b0, acc_reg[2*XLEN-1:XLEN]} + (acc_reg[0] ? {1'b0, mcand_reg} : '0);
  assign acc_step = {acc_sum, acc_reg[XLEN-1:1]};
  assign acc_fix  = neg_q_reg ? -acc_reg : acc_reg;
  assign mul_done = (cnt_reg == '0);
  assign mul_res  = want_low_reg ? acc_fix[XLEN-1:0] : acc_fix[2*XLEN-1:XLEN];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_reg   <= '0;
      mcand_reg <= '0;
      acc_reg   <= '0;
    end else if (accept) begin
      cnt_reg   <= CW'(XLEN);
      mcand_reg <= a_mag;
      acc_reg   <= {{XLEN{1'b0}}, b_mag};
    end else if (state_reg == S_MUL && cnt_reg != '0) begin
      cnt_reg <= cnt_reg - CW'(1);
      acc_reg <= acc_step;
    end
  end
`else
  logic [XLEN-1:0]          a_reg, b_reg;
  logic                     ext_a_reg, ext_b_reg;
  logic signed [XLEN:0]     a_ext, b_ext;
  logic signed [2*XLEN-1:0] a_wide, b_wide, prod;

  // Each operand is widened by one bit (sign or zero) so one signed multiply
  // covers the s*s, s*u and u*u flavours.
  assign a_ext    = {ext_a_reg & a_reg[XLEN-1], a_reg};
  assign b_ext    = {ext_b_reg & b_reg[XLEN-1], b_reg};
  assign a_wide   = {{(XLEN-1){a_ext[XLEN]}}, a_ext};
  assign b_wide   = {{(XLEN-1){b_ext[XLEN]}}, b_ext};
  assign prod     = a_wide * b_wide;
  assign mul_done = 1'b1;
  assign mul_res  = want_low_reg ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_reg     <= '0;
      b_reg     <= '0;
      ext_a_reg <= 1'b0;
      ext_b_reg <= 1'b0;
    end else if (accept) begin
      a_reg     <= rs1;
      b_reg     <= rs2;
      ext_a_reg <= op_sel[OP_MULH] | op_sel[OP_MULHSU];
      ext_b_reg <= op_sel[OP_MULH];
    end
  end
`endif

  // Request attributes
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      want_low_reg <= 1'b0;
      want_rem_reg <= 1'b0;
      special_reg  <= 1'b0;
      spec_val_reg <= '0;
      neg_q_reg    <= 1'b0;
      neg_r_reg    <= 1'b0;
    end else if (accept) begin
      want_low_reg <= op_sel[OP_MUL];
      want_rem_reg <= op_sel[OP_REM] | op_sel[OP_REMU];
      special_reg  <= special;
      spec_val_reg <= spec_val;
      neg_q_reg    <= neg_q;
      neg_r_reg    <= neg_r;
    end
  end

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg  <= S_IDLE;
      result_reg <= '0;
    end else begin
      state_reg  <= state_next;
      result_reg <= result_next;
    end
  end

  // FSM next state and outputs
  always_comb begin
    state_next  = state_reg;
    result_next = result_reg;
    in_ready    = (state_reg == S_IDLE);
    out_valid   = (state_reg == S_DONE);
    case (state_reg)
      S_IDLE: begin
        if (accept) begin
          state_next = is_mul ? S_MUL : S_DIV;
        end
      end
      S_MUL: begin
        if (mul_done) begin
          state_next  = S_DONE;
          result_next = mul_res;
        end
      end
      S_DIV: begin
        if (special_reg) begin
          state_next  = S_DONE;
          result_next = spec_val_reg;
        end else if (!div_busy) begin
          state_next  = S_DONE;
          result_next = div_res;
        end
      end
      S_DONE: begin
        if (out_ready) begin
          state_next = S_IDLE;
        end
      end
      default: state_next = S_IDLE;
    endcase
    // A kill wins over everything else; the last delivered result stays visible.
    if (flush) begin
      state_next  = S_IDLE;
      result_next = result_reg;
    end
  end

  assign result = result_reg;

endmodule

// File: tb/tb_mdu_unit.sv
// tb_mdu_unit: directed-vector bench for mdu_unit (XLEN=32), plus hand-written
// sequences for back-pressure, flush, async reset and a short random run
// against an arithmetic reference model.
module tb_mdu_unit;
  import mdu_unit_pkg::*;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic [7:0]      op = '0;
  logic [XLEN-1:0] rs1 = '0;
  logic [XLEN-1:0] rs2 = '0;
  logic            flush = 1'b0;
  logic            out_valid;
  logic            out_ready = 1'b0;
  logic [XLEN-1:0] result;

  always #5 clk = ~clk;

  mdu_unit dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .rs1       (rs1),
    .rs2       (rs2),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result)
  );

`ifdef MDU_ITER_MUL_EN
  localparam int MUL_LAT = 33;
`else
  localparam int MUL_LAT = 1;
`endif
  localparam int DIV_LAT = 33;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [7:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Present one request; returns #1 after the accept edge with inputs scrambled.
  task automatic issue(input logic [7:0] o, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    op = o; rs1 = a; rs2 = b; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    op = 8'($urandom); rs1 = $urandom; rs2 = $urandom;
  endtask

  // Edges after the accept edge until out_valid is seen (bounded).
  task automatic wait_result(output int lat);
    lat = 0;
    while (!out_valid && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic release_result(input string tag);
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check({tag, " back to idle"}, {62'd0, in_ready, out_valid}, 64'd2);
  endtask

  task automatic run(input logic [7:0] o, input logic [31:0] a, input logic [31:0] b,
                     input logic [31:0] exp, input int explat, input string tag);
    int lat;
    issue(o, a, b);
    wait_result(lat);
    check({tag, " latency"}, 64'(lat), 64'(explat));
    check({tag, " result"}, 64'(result), 64'(exp));
    $display("op=%02h rs1=%08h rs2=%08h -> result=%08h latency=%0d", o, a, b, result, lat);
    release_result(tag);
  endtask

  function automatic logic [31:0] ref_res(input int k, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] p;
    logic        ovf;
    ovf = (a == 32'h80000000) && (b == 32'hFFFFFFFF);
    case (k)
      0: begin p = {32'd0, a} * {32'd0, b}; return p[31:0]; end
      1: begin p = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b}); return p[63:32]; end
      2: begin p = $signed({{32{a[31]}}, a}) * $signed({32'd0, b}); return p[63:32]; end
      3: begin p = {32'd0, a} * {32'd0, b}; return p[63:32]; end
      4: return (b == 0) ? 32'hFFFFFFFF : ovf ? 32'h80000000 : 32'($signed(a) / $signed(b));
      5: return (b == 0) ? 32'hFFFFFFFF : a / b;
      6: return (b == 0) ? a : ovf ? 32'h0 : 32'($signed(a) % $signed(b));
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 7))
      0: return 32'h0;
      1: return 32'hFFFFFFFF;
      2: return 32'h80000000;
      3: return 32'($urandom_range(0, 15));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int lat;
    int seen;
    logic [31:0] held;

    vecs.push_back('{8'h01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, MUL_LAT});
    vecs.push_back('{8'h02, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, MUL_LAT});
    vecs.push_back('{8'h04, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, MUL_LAT});
    vecs.push_back('{8'h08, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, MUL_LAT});
    vecs.push_back('{8'h01, 32'h12345678, 32'h00000009, 32'hA3D70A38, MUL_LAT});
    vecs.push_back('{8'h02, 32'h80000000, 32'h80000000, 32'h40000000, MUL_LAT});
    vecs.push_back('{8'h04, 32'h80000000, 32'h80000000, 32'hC0000000, MUL_LAT});
    vecs.push_back('{8'h08, 32'h80000000, 32'h80000000, 32'h40000000, MUL_LAT});
    vecs.push_back('{8'h10, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFD, DIV_LAT});
    vecs.push_back('{8'h40, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, DIV_LAT});
    vecs.push_back('{8'h20, 32'hFFFFFFF9, 32'h00000002, 32'h7FFFFFFC, DIV_LAT});
    vecs.push_back('{8'h80, 32'hFFFFFFF9, 32'h00000002, 32'h00000001, DIV_LAT});
    vecs.push_back('{8'h10, 32'h00000064, 32'hFFFFFFF9, 32'hFFFFFFF2, DIV_LAT});
    vecs.push_back('{8'h40, 32'hFFFFFF9C, 32'h00000007, 32'hFFFFFFFE, DIV_LAT});
    vecs.push_back('{8'h80, 32'h00001234, 32'h00000010, 32'h00000004, DIV_LAT});
    vecs.push_back('{8'h10, 32'h00001234, 32'h00000000, 32'hFFFFFFFF, 1});
    vecs.push_back('{8'h20, 32'h00001234, 32'h00000000, 32'hFFFFFFFF, 1});
    vecs.push_back('{8'h40, 32'h00001234, 32'h00000000, 32'h00001234, 1});
    vecs.push_back('{8'h80, 32'h00001234, 32'h00000000, 32'h00001234, 1});
    vecs.push_back('{8'h10, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1});
    vecs.push_back('{8'h40, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 1});
    vecs.push_back('{8'h20, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, DIV_LAT});
    vecs.push_back('{8'h80, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, DIV_LAT});
    vecs.push_back('{8'h00, 32'h00001234, 32'h00005678, 32'h00000000, 1});
    vecs.push_back('{8'h30, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFD, DIV_LAT});
    vecs.push_back('{8'h81, 32'h00000003, 32'h00000005, 32'h0000000F, MUL_LAT});

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("reset in_ready", 64'(in_ready), 64'd1);
    check("reset out_valid", 64'(out_valid), 64'd0);
    check("reset result", 64'(result), 64'd0);
    @(negedge clk);
    rst = 1'b0;

    // Directed table
    foreach (vecs[i]) begin
      run(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].lat, $sformatf("vec%0d", i));
    end

    // Back-pressure: out_ready low for 5 cycles after DONE
    issue(8'h01, 32'd3, 32'd5);
    wait_result(lat);
    check("hold latency", 64'(lat), 64'(MUL_LAT));
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      check($sformatf("hold cycle%0d", c), {31'd0, out_valid, in_ready, result}, {31'd0, 1'b1, 1'b0, 32'd15});
    end
    $display("hold sequence: result=%08h", result);
    release_result("hold");
    held = 32'd15;

    // Flush 10 cycles into a division
    issue(8'h10, 32'd100, 32'd7);
    repeat (9) begin
      @(posedge clk); #1;
    end
    @(negedge clk);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    check("flush idle", {62'd0, in_ready, out_valid}, 64'd2);
    check("flush result kept", 64'(result), 64'(held));
    seen = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (out_valid) seen++;
    end
    check("flush no output", 64'(seen), 64'd0);
    $display("flush sequence: in_ready=%0b out_valid=%0b", in_ready, out_valid);
    run(8'h10, 32'd100, 32'd7, 32'd14, DIV_LAT, "after flush");

    // Flush beats out_ready in DONE
    issue(8'h20, 32'd100, 32'd7);
    wait_result(lat);
    check("flush-done latency", 64'(lat), 64'(DIV_LAT));
    @(negedge clk);
    flush = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0; out_ready = 1'b0;
    check("flush-done idle", {62'd0, in_ready, out_valid}, 64'd2);
    check("flush-done result", 64'(result), 64'd14);
    $display("flush in DONE: result=%08h", result);

    // Flush beats accept
    @(negedge clk);
    op = 8'h10; rs1 = 32'd9; rs2 = 32'd2; in_valid = 1'b1; flush = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; flush = 1'b0;
    check("flush-accept in_ready", 64'(in_ready), 64'd1);
    seen = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (out_valid) seen++;
    end
    check("flush-accept no output", 64'(seen), 64'd0);
    $display("flush vs accept: in_ready=%0b", in_ready);

    // Asynchronous reset mid-division
    issue(8'h10, 32'hFFFFFFF9, 32'd2);
    repeat (5) @(posedge clk);
    @(negedge clk);
    #1 rst = 1'b1;
    #1;
    check("rst-mid outputs", {31'd0, in_ready, out_valid, result}, {31'd0, 1'b1, 1'b0, 32'd0});
    $display("reset mid-div: in_ready=%0b out_valid=%0b result=%08h", in_ready, out_valid, result);
    @(negedge clk);
    rst = 1'b0;
    run(8'h10, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, DIV_LAT, "after rst");

    // Random ops against the reference model
    for (int n = 0; n < 150; n++) begin
      int k;
      int explat;
      logic [31:0] a, b;
      k = $urandom_range(0, 7);
      a = pick_operand();
      b = pick_operand();
      if (k < 4) explat = MUL_LAT;
      else if (b == 0 || ((k == 4 || k == 6) && a == 32'h80000000 && b == 32'hFFFFFFFF)) explat = 1;
      else explat = DIV_LAT;
      run(8'(1 << k), a, b, ref_res(k, a, b), explat, $sformatf("rand%0d", n));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
